// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder for a bit-serial adder: captures an operand pair,
// pulses carry_clr for one cycle, then streams both operands LSB first.
module serial_operand_feeder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             a,
    output logic             b,
    output logic             carry_clr,
    output logic             bit_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CLEAR = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] sreg_a_q;
    logic [WIDTH-1:0] sreg_a_d;
    logic [WIDTH-1:0] sreg_b_q;
    logic [WIDTH-1:0] sreg_b_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             at_last_s;

    assign at_last_s = (cnt_q == LAST_CNT);

    // Next-state, operand capture and shift/count logic.
    always_comb begin
        state_d  = state_q;
        sreg_a_d = sreg_a_q;
        sreg_b_d = sreg_b_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d  = ST_CLEAR;
                    sreg_a_d = op_a;
                    sreg_b_d = op_b;
                    cnt_d    = {CW{1'b0}};
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_SHIFT;
                cnt_d   = {CW{1'b0}};
            end
            ST_SHIFT: begin
                sreg_a_d = sreg_a_q >> 1'b1;
                sreg_b_d = sreg_b_q >> 1'b1;
                if (at_last_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_SHIFT;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean idle.
                state_d  = ST_IDLE;
                sreg_a_d = {WIDTH{1'b0}};
                sreg_b_d = {WIDTH{1'b0}};
                cnt_d    = {CW{1'b0}};
            end
        endcase
    end

    // State, shift-register and counter flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            sreg_a_q <= {WIDTH{1'b0}};
            sreg_b_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            sreg_a_q <= sreg_a_d;
            sreg_b_q <= sreg_b_d;
            cnt_q    <= cnt_d;
        end
    end

    // Output decode from registered state only; a/b are forced low outside SHIFT.
    always_comb begin
        in_ready  = 1'b1;
        busy      = 1'b0;
        carry_clr = 1'b0;
        bit_valid = 1'b0;
        last      = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_CLEAR: begin
                in_ready  = 1'b0;
                busy      = 1'b1;
                carry_clr = 1'b1;
            end
            ST_SHIFT: begin
                in_ready  = 1'b0;
                busy      = 1'b1;
                bit_valid = 1'b1;
                last      = at_last_s;
                a         = sreg_a_q[0];
                b         = sreg_b_q[0];
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: WIDTH=8 and WIDTH=1 instances against a queue-based
// schedule model of the expected per-cycle output vector.
module tb_serial_operand_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid8, in_ready8, a8, b8, carry_clr8, bit_valid8, last8, busy8;
    logic [7:0] op_a8, op_b8;
    logic       in_valid1, in_ready1, a1, b1, carry_clr1, bit_valid1, last1, busy1;
    logic [0:0] op_a1, op_b1;

    logic [6:0] obs8, obs1;
    logic [6:0] q8[$];
    logic [6:0] q1[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    localparam logic [6:0] IDLE_V  = 7'b1000000;
    localparam logic [6:0] CLEAR_V = 7'b0110000;

    always #5 clk = ~clk;

    serial_operand_feeder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .op_a(op_a8), .op_b(op_b8), .a(a8), .b(b8), .carry_clr(carry_clr8),
        .bit_valid(bit_valid8), .last(last8), .busy(busy8)
    );

    serial_operand_feeder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .a(a1), .b(b1), .carry_clr(carry_clr1),
        .bit_valid(bit_valid1), .last(last1), .busy(busy1)
    );

    // {in_ready, busy, carry_clr, bit_valid, last, a, b}
    assign obs8 = {in_ready8, busy8, carry_clr8, bit_valid8, last8, a8, b8};
    assign obs1 = {in_ready1, busy1, carry_clr1, bit_valid1, last1, a1, b1};

    function automatic logic [6:0] exp8_f();
        return (q8.size() == 0) ? IDLE_V : q8[0];
    endfunction

    function automatic logic [6:0] exp1_f();
        return (q1.size() == 0) ? IDLE_V : q1[0];
    endfunction

    // One clock: the model retires the finished cycle or schedules a new operation, then sample at negedge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!reset) begin
            q8.delete();
            q1.delete();
        end else begin
            if (q8.size() != 0) begin
                void'(q8.pop_front());
            end else if (in_valid8) begin
                q8.push_back(CLEAR_V);
                for (int i = 0; i < 8; i++)
                    q8.push_back({1'b0, 1'b1, 1'b0, 1'b1, (i == 7), op_a8[i], op_b8[i]});
            end
            if (q1.size() != 0) begin
                void'(q1.pop_front());
            end else if (in_valid1) begin
                q1.push_back(CLEAR_V);
                q1.push_back({1'b0, 1'b1, 1'b0, 1'b1, 1'b1, op_a1[0], op_b1[0]});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid8 = 1'b1; op_a8 = 8'h5A; op_b8 = 8'hC3;
        in_valid1 = 1'b1; op_a1 = 1'b1; op_b1 = 1'b1;
        #1;
        total++;
        if (obs8 !== IDLE_V) begin bad++; $display("FAIL reset_state8 got=%b exp=%b", obs8, IDLE_V); end
        total++;
        if (obs1 !== IDLE_V) begin bad++; $display("FAIL reset_state1 got=%b exp=%b", obs1, IDLE_V); end
        repeat (2) begin
            tick();
            total++;
            if (obs8 !== IDLE_V) begin bad++; $display("FAIL reset_no_handshake8 t=%0d got=%b exp=%b", cyc, obs8, IDLE_V); end
            total++;
            if (obs1 !== IDLE_V) begin bad++; $display("FAIL reset_no_handshake1 t=%0d got=%b exp=%b", cyc, obs1, IDLE_V); end
        end
        reset = 1'b1; in_valid8 = 1'b0; in_valid1 = 1'b0;
        tick();
        total++;
        if (obs8 !== IDLE_V) begin bad++; $display("FAIL reset_release8 got=%b exp=%b", obs8, IDLE_V); end
    endtask

    task automatic test_basic();
        logic [7:0] ga, gb;
        int n, clr, last_at;
        ga = 8'h00; gb = 8'h00; n = 0; clr = 0; last_at = -1;
        op_a8 = 8'hA5; op_b8 = 8'h3C; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        for (int c = 0; c < 11; c++) begin
            total++;
            if (obs8 !== exp8_f()) begin bad++; $display("FAIL basic_cycle t=%0d got=%b exp=%b", cyc, obs8, exp8_f()); end
            if (carry_clr8) clr++;
            if (bit_valid8 && n < 8) begin
                ga[n] = a8; gb[n] = b8;
                if (last8) last_at = n;
                n++;
            end
            tick();
        end
        total++;
        if (ga !== 8'hA5) begin bad++; $display("FAIL basic_stream_a got=%h exp=a5", ga); end
        total++;
        if (gb !== 8'h3C) begin bad++; $display("FAIL basic_stream_b got=%h exp=3c", gb); end
        total++;
        if (n != 8 || clr != 1 || last_at != 7) begin
            bad++; $display("FAIL basic_counts bits=%0d clr=%0d last_at=%0d exp 8/1/7", n, clr, last_at);
        end
    endtask

    task automatic test_ignored();
        logic [7:0] ga;
        int n, clr;
        ga = 8'h00; n = 0; clr = 0;
        op_a8 = 8'hA5; op_b8 = 8'h3C; in_valid8 = 1'b1;
        tick();
        op_a8 = 8'hFF;
        for (int c = 0; c < 12; c++) begin
            total++;
            if (obs8 !== exp8_f()) begin bad++; $display("FAIL ignored_cycle t=%0d got=%b exp=%b", cyc, obs8, exp8_f()); end
            if (carry_clr8) clr++;
            if (bit_valid8 && n < 8) begin ga[n] = a8; n++; end
            in_valid8 = (c < 6);
            tick();
        end
        total++;
        if (ga !== 8'hA5 || clr != 1) begin bad++; $display("FAIL ignored_stream a=%h clr=%0d exp a5/1", ga, clr); end
    endtask

    task automatic test_back_to_back();
        int clr, busy_n, first_clr, second_clr;
        clr = 0; busy_n = 0; first_clr = -1; second_clr = -1;
        op_a8 = 8'h01; op_b8 = 8'h01; in_valid8 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            total++;
            if (obs8 !== exp8_f()) begin bad++; $display("FAIL b2b_cycle t=%0d got=%b exp=%b", cyc, obs8, exp8_f()); end
            if (busy8) busy_n++;
            if (carry_clr8) begin
                clr++;
                if (clr == 1) begin first_clr = c; op_a8 = 8'hFF; op_b8 = 8'h01; end
                if (clr == 2) begin second_clr = c; in_valid8 = 1'b0; end
            end
            tick();
        end
        total++;
        if (clr != 2 || busy_n != 18 || (second_clr - first_clr) != 10) begin
            bad++; $display("FAIL b2b_timing clr=%0d busy=%0d gap=%0d exp 2/18/10", clr, busy_n, second_clr - first_clr);
        end
    endtask

    task automatic test_mid_reset();
        int bv, late_bv;
        bv = 0; late_bv = 0;
        op_a8 = 8'($urandom); op_b8 = 8'($urandom); in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        for (int c = 0; c < 20 && bv < 3; c++) begin
            total++;
            if (obs8 !== exp8_f()) begin bad++; $display("FAIL midrst_pre t=%0d got=%b exp=%b", cyc, obs8, exp8_f()); end
            if (bit_valid8) bv++;
            tick();
        end
        total++;
        if (bv != 3) begin bad++; $display("FAIL midrst_bound bit_valid cycles=%0d exp 3", bv); end
        reset = 1'b0; q8.delete(); q1.delete();
        #1;
        total++;
        if (obs8 !== IDLE_V) begin bad++; $display("FAIL midrst_immediate got=%b exp=%b", obs8, IDLE_V); end
        in_valid8 = 1'b1;
        repeat (2) begin
            tick();
            total++;
            if (obs8 !== IDLE_V) begin bad++; $display("FAIL midrst_hold t=%0d got=%b exp=%b", cyc, obs8, IDLE_V); end
        end
        reset = 1'b1; in_valid8 = 1'b0;
        repeat (10) begin
            tick();
            total++;
            if (obs8 !== exp8_f()) begin bad++; $display("FAIL midrst_after t=%0d got=%b exp=%b", cyc, obs8, exp8_f()); end
            if (bit_valid8) late_bv++;
        end
        total++;
        if (late_bv != 0) begin bad++; $display("FAIL midrst_no_bits got=%0d exp=0", late_bv); end
    endtask

    task automatic test_adder_chain();
        logic [7:0] sum;
        logic       carry, s;
        int         n, exp_sum;
        sum = 8'h00; carry = 1'b1; n = 0;
        exp_sum = (200 + 100) % 256;
        op_a8 = 8'd200; op_b8 = 8'd100; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        for (int c = 0; c < 11; c++) begin
            total++;
            if (obs8 !== exp8_f()) begin bad++; $display("FAIL adder_cycle t=%0d got=%b exp=%b", cyc, obs8, exp8_f()); end
            if (carry_clr8) carry = 1'b0;
            if (bit_valid8 && n < 8) begin
                s = a8 ^ b8 ^ carry;
                carry = (a8 & b8) | (a8 & carry) | (b8 & carry);
                sum[n] = s;
                n++;
            end
            tick();
        end
        total++;
        if (sum !== exp_sum[7:0]) begin bad++; $display("FAIL adder_sum got=%0d exp=%0d", sum, exp_sum); end
    endtask

    task automatic test_width1();
        int clr, bv;
        logic seen_last, ga, gb;
        clr = 0; bv = 0; seen_last = 1'b0; ga = 1'b0; gb = 1'b0;
        op_a1 = 1'b1; op_b1 = 1'b1; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (obs1 !== exp1_f()) begin bad++; $display("FAIL w1_cycle t=%0d got=%b exp=%b", cyc, obs1, exp1_f()); end
            if (carry_clr1) clr++;
            if (bit_valid1) begin bv++; seen_last = last1; ga = a1; gb = b1; end
            tick();
        end
        total++;
        if (clr != 1 || bv != 1 || seen_last !== 1'b1 || ga !== 1'b1 || gb !== 1'b1) begin
            bad++; $display("FAIL w1_summary clr=%0d bv=%0d last=%b a=%b b=%b exp 1/1/1/1/1", clr, bv, seen_last, ga, gb);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid8 = ($urandom_range(0, 3) != 0);
            op_a8 = 8'($urandom); op_b8 = 8'($urandom);
            in_valid1 = ($urandom_range(0, 1) != 0);
            op_a1 = 1'($urandom); op_b1 = 1'($urandom);
            tick();
            total++;
            if (obs8 !== exp8_f()) begin bad++; $display("FAIL random8 t=%0d got=%b exp=%b", cyc, obs8, exp8_f()); end
            total++;
            if (obs1 !== exp1_f()) begin bad++; $display("FAIL random1 t=%0d got=%b exp=%b", cyc, obs1, exp1_f()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored();
        test_back_to_back();
        test_mid_reset();
        test_adder_chain();
        test_width1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
